led_seq_v3: RTL
===============

// Module: led_seq_v3
// PURPOSE
//  Parametrised successor of the v2 counter/LED path: a programmable tick generator
//  with four selectable period limits. It drives a LED pattern sequencer with four modes
//  (rotate left, rotate right, ping-pong, flash). Sits between the board switches and the LED bank in top.
// PARAMETERS
//  DATA_WIDTH  14  width of the period counter
//  LED_WIDTH   4   number of LEDs driven (>= 2)
//  LIMIT0      16  period in clocks for i_sel=2'b00 (320 ns at 50 MHz)
//  LIMIT1      8   period in clocks for i_sel=2'b01 (160 ns)
//  LIMIT2      4   period in clocks for i_sel=2'b10 (80 ns)
//  LIMIT3      2   period in clocks for i_sel=2'b11 (40 ns); all LIMITx in [2, 2**DATA_WIDTH-1]
// PORTS
//  clock     in   1           system clock, all logic on rising edge
//  i_reset   in   1           asynchronous, active-low reset
//  i_enable  in   1           1: count and sequence; 0: hold everything
//  i_sel     in   2           period limit select
//  i_mode    in   2           00 rotate left, 01 rotate right, 10 ping-pong, 11 flash
//  o_led     out  LED_WIDTH   LED pattern
//  o_valid   out  1           one-clock tick strobe
//  o_count   out  DATA_WIDTH  current counter value (debug)
// BEHAVIOUR
//  Reset (i_reset=0, async): o_count=0, o_valid=0, o_led={0..0,1}, dir=up; held while low.
//  Release is synchronous in effect: first count increment on the first rising edge with i_reset=1.
//  Counter: lim = LIMIT[i_sel], sampled every cycle (no latching).
//   - i_enable=1 and o_count >= lim-1: next o_count=0, next o_valid=1 (tick).
//   - i_enable=1 otherwise: o_count+1, o_valid=0.
//   - i_enable=0: o_count holds, o_valid=0, o_led and dir hold.
//   - Using >= rather than == is required. If i_sel shrinks the limit below the current count,
//     the counter wraps on the next edge with a tick, never running to 2**DATA_WIDTH.
//   - Steady period is exactly lim clocks between o_valid pulses; o_valid is high for one clock.
//  Sequencer: o_led updates on the same edge that sets o_valid=1.
//   - i_mode is sampled at that edge; mode changes between ticks have no effect until then.
//   - Modes 00/01/10 with a non-one-hot o_led (e.g. after flash): reload {0..0,1}, dir=up.
//   - 00: rotate left, MSB wraps to bit 0.
//   - 01: rotate right, bit 0 wraps to MSB.
//   - 10 ping-pong, dir=up: if o_led[MSB] then dir<=down and shift right 1, else shift left 1.
//   - 10 ping-pong, dir=down: if o_led[0] then dir<=up and shift left 1, else shift right 1.
//   - 11 flash: if o_led all ones then all zeros, else all ones; dir unchanged.
//  All outputs registered; no combinational path from inputs to outputs.
//  Reset mid-count or mid-pattern returns all state to reset values immediately.
// TESTING
//  1 Reset 20 ns low, then i_enable=1, i_sel=00, mode=00: o_valid every 16 clk;
//    o_led 0001->0010->0100->1000->0001.
//  2 sel 00->01->10->11 at steady state: tick spacing 16/8/4/2 clk.
//    Switch 00->11 while o_count=10: tick on next edge, then spacing 2.
//  3 mode=01 from 0001: 1000,0100,0010,0001. mode=10 from 0001:
//    0010,0100,1000,0100,0010,0001,0010 (bounces at both ends).
//  4 mode=11 from 0100: 1111,0000,1111. Then mode=00: next tick gives 0001.
//  5 i_enable=0 for 5 clk at o_count=3: o_count stays 3, no o_valid, o_led frozen.
//    Re-enable: tick lim-3 clk later.
//  6 Assert i_reset mid-count (o_count=7, o_led=0100) off-edge: outputs go to 0/0001/0 without a clock edge.

Source files
------------

// File: rtl/led_seq_v3.sv
// Programmable tick generator with four selectable periods driving a LED
// pattern sequencer (rotate left/right, ping-pong, flash).
module led_seq_v3 #(
  parameter int DATA_WIDTH = 14,
  parameter int LED_WIDTH  = 4,
  parameter int LIMIT0     = 16,
  parameter int LIMIT1     = 8,
  parameter int LIMIT2     = 4,
  parameter int LIMIT3     = 2
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [1:0]            i_sel,
  input  logic [1:0]            i_mode,
  output logic [LED_WIDTH-1:0]  o_led,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_count
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  localparam logic [LED_WIDTH-1:0] LED_INIT = {{(LED_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LED_WIDTH-1:0] LED_ZERO = {LED_WIDTH{1'b0}};
  localparam logic [LED_WIDTH-1:0] LED_ONES = {LED_WIDTH{1'b1}};

  function automatic logic is_onehot(input logic [LED_WIDTH-1:0] v);
    return (v != LED_ZERO) && ((v & (v - LED_INIT)) == LED_ZERO);
  endfunction

  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  valid_q, valid_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;
  dir_e                  dir_q, dir_d;
  logic [DATA_WIDTH-1:0] lim_s;

  // Period limit follows i_sel every cycle; no latching.
  always_comb begin
    case (i_sel)
      2'b00:   lim_s = DATA_WIDTH'(LIMIT0);
      2'b01:   lim_s = DATA_WIDTH'(LIMIT1);
      2'b10:   lim_s = DATA_WIDTH'(LIMIT2);
      2'b11:   lim_s = DATA_WIDTH'(LIMIT3);
      default: lim_s = DATA_WIDTH'(LIMIT0);
    endcase
  end

  // Counter, tick strobe and pattern next-state; >= lets a shrunk limit wrap at once.
  always_comb begin
    count_d = count_q;
    valid_d = 1'b0;
    led_d   = led_q;
    dir_d   = dir_q;
    if (i_enable) begin
      if (count_q >= lim_s - DATA_WIDTH'(1)) begin
        count_d = {DATA_WIDTH{1'b0}};
        valid_d = 1'b1;
        if (i_mode == 2'b11) begin
          led_d = (led_q == LED_ONES) ? LED_ZERO : LED_ONES;
        end else if (!is_onehot(led_q)) begin
          led_d = LED_INIT;
          dir_d = DIR_UP;
        end else begin
          case (i_mode)
            2'b00: led_d = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
            2'b01: led_d = {led_q[0], led_q[LED_WIDTH-1:1]};
            default: begin
              if (dir_q == DIR_UP) begin
                if (led_q[LED_WIDTH-1]) begin
                  dir_d = DIR_DOWN;
                  led_d = {1'b0, led_q[LED_WIDTH-1:1]};
                end else begin
                  led_d = {led_q[LED_WIDTH-2:0], 1'b0};
                end
              end else begin
                if (led_q[0]) begin
                  dir_d = DIR_UP;
                  led_d = {led_q[LED_WIDTH-2:0], 1'b0};
                end else begin
                  led_d = {1'b0, led_q[LED_WIDTH-1:1]};
                end
              end
            end
          endcase
        end
      end else begin
        count_d = count_q + DATA_WIDTH'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= {DATA_WIDTH{1'b0}};
      valid_q <= 1'b0;
      led_q   <= LED_INIT;
      dir_q   <= DIR_UP;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
    end
  end

  assign o_count = count_q;
  assign o_valid = valid_q;
  assign o_led   = led_q;

endmodule
